xix4_prefix_sequencer: RTL and testbench
========================================

Name: xix4_prefix_sequencer

Overview:
- Upstream sequencer for the indexed bit-operation decode stage.
- Tracks the DD/FD → CB → d → op prefix chain from the fetch stream, then enters the XIX4/XIY4 execute phase.
- Latches the displacement and the final opcode (Source), and runs the 4-bit XPT step counter the decoder consumes.
- Applies the decoder's reset strobes (XPT reset, XIX4/XIY4 reset) to end the phase.

Parameters:
- XPT_MAX, 15, terminal XPT value; counter saturates here and flags overflow.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- fetch_valid  in  1  fetch_byte carries a newly fetched opcode-stream byte this cycle.
- fetch_byte  in  8  fetched byte.
- hold  in  1  memory wait; freezes the XPT counter and ignores fetch_valid.
- PR_Reset_XPT  in  1  from decoder; clear XPT.
- P2_Reset_XIX4  in  1  from decoder; clear XIX4 phase.
- P2_Reset_XIY4  in  1  from decoder; clear XIY4 phase.
- XPT  out  4  step counter.
- notXPT  out  4  bitwise complement of XPT.
- Source  out  8  latched opcode byte (4th byte of DD/FD CB d op).
- notSource  out  8  complement of Source.
- Disp  out  8  latched displacement d.
- is_Y  out  1  1 = FD (IY) chain, 0 = DD (IX).
- not_enable  out  1  active-low decoder enable; 0 only in EXEC.
- XIX4  out  1  EXEC and ~is_Y.
- XIY4  out  1  EXEC and is_Y.
- pfx_plain  out  1  one-cycle pulse: DD/FD followed by a non-CB, non-prefix byte.
- xpt_overflow  out  1  sticky; XPT reached XPT_MAX while in EXEC.

Behaviour:
- States: IDLE, PFX, CBD, CBO, EXEC. Reset → IDLE.
- Reset values: XPT=0, Source=0, Disp=0, is_Y=0, not_enable=1, XIX4=XIY4=0, pfx_plain=0, xpt_overflow=0. Complement outputs are always exact complements, including during reset.
- Fetch acceptance: a byte is consumed only when fetch_valid=1 and hold=0.
- IDLE:
  - byte DD → PFX with is_Y=0.
  - byte FD → PFX with is_Y=1.
  - any other byte → stay in IDLE.
- PFX:
  - byte CB → CBD.
  - byte DD/FD → stay in PFX; is_Y is updated (last prefix wins).
  - other byte → Source=byte, pfx_plain=1 for one cycle, next state IDLE.
- CBD: accepted byte → Disp, next state CBO.
- CBO: accepted byte → Source, XPT=0, next state EXEC.
- not_enable falls in the first EXEC cycle.
- EXEC:
  - Each cycle with hold=0, XPT increments by 1; it saturates at XPT_MAX and sets xpt_overflow.
  - With hold=1, XPT is frozen.
  - fetch_valid is ignored.
- PR_Reset_XPT=1: XPT=0 next cycle. Takes priority over increment and over hold.
- Phase end: P2_Reset_XIX4 with is_Y=0, or P2_Reset_XIY4 with is_Y=1 → IDLE next cycle.
  - not_enable=1 and XIX4/XIY4=0 at that point.
  - Source and Disp are retained.
  - A reset strobe for the non-matching index register is ignored.
- Simultaneous PR_Reset_XPT and phase end in the same cycle: IDLE with XPT=0.
- Reset strobes arriving outside EXEC: XPT is cleared; state is otherwise unaffected.
- hold=1 in PFX/CBD/CBO: the state is frozen.
- xpt_overflow clears only on RESET.
- RESET mid-EXEC: everything returns to reset values next edge, regardless of other inputs.

Test Plan:
- DD, CB, 05, 46 (one fetch per cycle) → Disp=05, Source=46, is_Y=0, XIX4=1, not_enable=0; XPT counts 0,1,2,… on following cycles.
- FD, CB, FE, C6; hold=1 for 2 cycles at XPT=3 → is_Y=1, XIY4=1; XPT stays 3 for 2 cycles, then goes to 4.
- In EXEC at XPT=11, assert PR_Reset_XPT and P2_Reset_XIX4 together (IX chain) → next cycle IDLE, XPT=0, not_enable=1, Source retained.
- Prefix chain:
  - DD, FD, CB, 10, 06 → is_Y=1, Disp=10, Source=06.
  - Separately, DD, 21 → pfx_plain pulses one cycle with Source=21, then IDLE.
- EXEC with no reset strobes for 20 cycles → XPT saturates at 15; xpt_overflow=1 and stays set until RESET.
- RESET asserted while in EXEC with XPT=7 → next edge: all outputs at reset values; notXPT=F, notSource=FF.

Source files
------------

// File: rtl/xix4_prefix_sequencer.sv
// Prefix-chain tracker for indexed bit operations: follows DD/FD -> CB -> d -> op,
// latches Disp/Source, and runs the XPT step counter during the XIX4/XIY4 phase.
module xix4_prefix_sequencer #(
  parameter logic [3:0] XPT_MAX = 4'd15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       fetch_valid,
  input  logic [7:0] fetch_byte,
  input  logic       hold,
  input  logic       PR_Reset_XPT,
  input  logic       P2_Reset_XIX4,
  input  logic       P2_Reset_XIY4,
  output logic [3:0] XPT,
  output logic [3:0] notXPT,
  output logic [7:0] Source,
  output logic [7:0] notSource,
  output logic [7:0] Disp,
  output logic       is_Y,
  output logic       not_enable,
  output logic       XIX4,
  output logic       XIY4,
  output logic       pfx_plain,
  output logic       xpt_overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PFX,
    S_CBD,
    S_CBO,
    S_EXEC
  } state_t;

  localparam logic [7:0] BYTE_DD = 8'hDD;
  localparam logic [7:0] BYTE_FD = 8'hFD;
  localparam logic [7:0] BYTE_CB = 8'hCB;

  state_t     state_q;
  logic [3:0] xpt_q;
  logic [7:0] source_q;
  logic [7:0] disp_q;
  logic       is_y_q;
  logic       not_enable_q;
  logic       xix4_q;
  logic       xiy4_q;
  logic       pfx_plain_q;
  logic       ovf_q;

  logic accept;
  logic is_prefix;
  logic phase_end;
  logic any_strobe;

  assign accept     = fetch_valid && !hold;
  assign is_prefix  = (fetch_byte == BYTE_DD) || (fetch_byte == BYTE_FD);
  assign phase_end  = (P2_Reset_XIX4 && !is_y_q) || (P2_Reset_XIY4 && is_y_q);
  assign any_strobe = PR_Reset_XPT || P2_Reset_XIX4 || P2_Reset_XIY4;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      xpt_q        <= '0;
      source_q     <= '0;
      disp_q       <= '0;
      is_y_q       <= 1'b0;
      not_enable_q <= 1'b1;
      xix4_q       <= 1'b0;
      xiy4_q       <= 1'b0;
      pfx_plain_q  <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      pfx_plain_q <= 1'b0;
      case (state_q)
        S_EXEC: begin
          // XPT clear beats both the increment and hold; overflow flags on reaching the limit.
          if (PR_Reset_XPT) begin
            xpt_q <= '0;
          end else if (!hold) begin
            if (xpt_q != XPT_MAX) xpt_q <= xpt_q + 4'd1;
            if (xpt_q >= XPT_MAX - 4'd1) ovf_q <= 1'b1;
          end
          if (phase_end) begin
            state_q      <= S_IDLE;
            not_enable_q <= 1'b1;
            xix4_q       <= 1'b0;
            xiy4_q       <= 1'b0;
          end
        end
        default: begin
          if (any_strobe) xpt_q <= '0;
          if (accept) begin
            case (state_q)
              S_IDLE: begin
                if (is_prefix) begin
                  state_q <= S_PFX;
                  is_y_q  <= (fetch_byte == BYTE_FD);
                end
              end
              S_PFX: begin
                if (fetch_byte == BYTE_CB) begin
                  state_q <= S_CBD;
                end else if (is_prefix) begin
                  is_y_q <= (fetch_byte == BYTE_FD);
                end else begin
                  source_q    <= fetch_byte;
                  pfx_plain_q <= 1'b1;
                  state_q     <= S_IDLE;
                end
              end
              S_CBD: begin
                disp_q  <= fetch_byte;
                state_q <= S_CBO;
              end
              S_CBO: begin
                source_q     <= fetch_byte;
                xpt_q        <= '0;
                state_q      <= S_EXEC;
                not_enable_q <= 1'b0;
                xix4_q       <= !is_y_q;
                xiy4_q       <= is_y_q;
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign XPT          = xpt_q;
  assign notXPT       = ~xpt_q;
  assign Source       = source_q;
  assign notSource    = ~source_q;
  assign Disp         = disp_q;
  assign is_Y         = is_y_q;
  assign not_enable   = not_enable_q;
  assign XIX4         = xix4_q;
  assign XIY4         = xiy4_q;
  assign pfx_plain    = pfx_plain_q;
  assign xpt_overflow = ovf_q;

endmodule

// File: tb/tb_xix4_prefix_sequencer.sv
// Directed bench for xix4_prefix_sequencer: a chain-parsing model checked every cycle,
// plus literal expectations along the test-plan sequences.
module tb_xix4_prefix_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       fetch_valid;
  logic [7:0] fetch_byte;
  logic       hold;
  logic       PR_Reset_XPT;
  logic       P2_Reset_XIX4;
  logic       P2_Reset_XIY4;
  logic [3:0] XPT, notXPT;
  logic [7:0] Source, notSource, Disp;
  logic       is_Y, not_enable, XIX4, XIY4, pfx_plain, xpt_overflow;

  int tests = 0;
  int fails = 0;

  xix4_prefix_sequencer #(.XPT_MAX(4'd15)) dut (
    .CLK(CLK), .RESET(RESET), .fetch_valid(fetch_valid), .fetch_byte(fetch_byte),
    .hold(hold), .PR_Reset_XPT(PR_Reset_XPT), .P2_Reset_XIX4(P2_Reset_XIX4),
    .P2_Reset_XIY4(P2_Reset_XIY4), .XPT(XPT), .notXPT(notXPT), .Source(Source),
    .notSource(notSource), .Disp(Disp), .is_Y(is_Y), .not_enable(not_enable),
    .XIX4(XIX4), .XIY4(XIY4), .pfx_plain(pfx_plain), .xpt_overflow(xpt_overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes of the chain seen so far, plus phase flag and latched values.
  logic [7:0] chain[$];
  logic [3:0] m_xpt;
  logic [7:0] m_src, m_disp;
  bit         m_isy, m_exec, m_plain, m_ovf;
  bit         m_valid = 0;

  always @(posedge CLK) begin
    if (RESET) begin
      chain.delete();
      m_xpt = 0; m_src = 0; m_disp = 0;
      m_isy = 0; m_exec = 0; m_plain = 0; m_ovf = 0;
      m_valid = 1;
    end else begin
      m_plain = 0;
      if (m_exec) begin
        if (PR_Reset_XPT) m_xpt = 0;
        else if (!hold) begin
          if (m_xpt < 15) m_xpt = m_xpt + 1;
          if (m_xpt == 15) m_ovf = 1;
        end
        if ((P2_Reset_XIX4 && !m_isy) || (P2_Reset_XIY4 && m_isy)) m_exec = 0;
      end else begin
        if (PR_Reset_XPT || P2_Reset_XIX4 || P2_Reset_XIY4) m_xpt = 0;
        if (fetch_valid && !hold) begin
          if (chain.size() == 0) begin
            if (fetch_byte == 8'hDD || fetch_byte == 8'hFD) begin
              chain.push_back(fetch_byte);
              m_isy = (fetch_byte == 8'hFD);
            end
          end else if (chain.size() == 1) begin
            if (fetch_byte == 8'hCB) chain.push_back(fetch_byte);
            else if (fetch_byte == 8'hDD || fetch_byte == 8'hFD) begin
              chain[0] = fetch_byte;
              m_isy = (fetch_byte == 8'hFD);
            end else begin
              m_src = fetch_byte; m_plain = 1; chain.delete();
            end
          end else if (chain.size() == 2) begin
            m_disp = fetch_byte; chain.push_back(fetch_byte);
          end else begin
            m_src = fetch_byte; m_xpt = 0; m_exec = 1; chain.delete();
          end
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("XPT", {4'h0, XPT}, {4'h0, m_xpt});
      chk("notXPT", {4'h0, notXPT}, {4'h0, ~m_xpt});
      chk("Source", Source, m_src);
      chk("notSource", notSource, ~m_src);
      chk("Disp", Disp, m_disp);
      chk("is_Y", {7'h0, is_Y}, {7'h0, m_isy});
      chk("not_enable", {7'h0, not_enable}, {7'h0, !m_exec});
      chk("XIX4", {7'h0, XIX4}, {7'h0, m_exec && !m_isy});
      chk("XIY4", {7'h0, XIY4}, {7'h0, m_exec && m_isy});
      chk("pfx_plain", {7'h0, pfx_plain}, {7'h0, m_plain});
      chk("xpt_overflow", {7'h0, xpt_overflow}, {7'h0, m_ovf});
    end
  end

  task automatic cyc(input bit fv, input logic [7:0] b, input bit h,
                     input bit pr, input bit px, input bit py);
    fetch_valid = fv; fetch_byte = b; hold = h;
    PR_Reset_XPT = pr; P2_Reset_XIX4 = px; P2_Reset_XIY4 = py;
    @(negedge CLK);
  endtask

  task automatic feed(input logic [7:0] b);
    cyc(1, b, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, 0, 0);
  endtask

  initial begin
    RESET = 1;
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0);
    chk("rst_XPT", {4'h0, XPT}, 8'h00);
    chk("rst_notXPT", {4'h0, notXPT}, 8'h0F);
    chk("rst_notSource", notSource, 8'hFF);
    chk("rst_not_enable", {7'h0, not_enable}, 8'h01);
    RESET = 0;

    // IX chain, counting, then simultaneous XPT clear and phase end at XPT=11
    feed(8'hDD); feed(8'hCB); feed(8'h05); feed(8'h46);
    chk("ix_Disp", Disp, 8'h05);
    chk("ix_Source", Source, 8'h46);
    chk("ix_XIX4", {7'h0, XIX4}, 8'h01);
    chk("ix_not_enable", {7'h0, not_enable}, 8'h00);
    chk("ix_XPT0", {4'h0, XPT}, 8'h00);
    idle(1); chk("ix_XPT1", {4'h0, XPT}, 8'h01);
    idle(1); chk("ix_XPT2", {4'h0, XPT}, 8'h02);
    idle(9); chk("ix_XPT11", {4'h0, XPT}, 8'h0B);
    cyc(0, 8'h00, 0, 1, 1, 0);
    chk("end_XPT", {4'h0, XPT}, 8'h00);
    chk("end_not_enable", {7'h0, not_enable}, 8'h01);
    chk("end_Source", Source, 8'h46);

    // IY chain with hold at XPT=3; mismatched strobe ignored
    feed(8'hFD); feed(8'hCB); feed(8'hFE); feed(8'hC6);
    chk("iy_is_Y", {7'h0, is_Y}, 8'h01);
    chk("iy_XIY4", {7'h0, XIY4}, 8'h01);
    idle(3); chk("iy_XPT3", {4'h0, XPT}, 8'h03);
    cyc(0, 8'h00, 1, 0, 0, 0); chk("iy_hold1", {4'h0, XPT}, 8'h03);
    cyc(1, 8'hDD, 1, 0, 0, 0); chk("iy_hold2", {4'h0, XPT}, 8'h03);
    idle(1); chk("iy_XPT4", {4'h0, XPT}, 8'h04);
    cyc(0, 8'h00, 0, 0, 1, 0); chk("iy_wrong_strobe", {7'h0, XIY4}, 8'h01);
    cyc(0, 8'h00, 0, 0, 0, 1); chk("iy_end", {7'h0, not_enable}, 8'h01);

    // Double prefix, then saturation and sticky overflow
    feed(8'hDD); feed(8'hFD); feed(8'hCB); feed(8'h10); feed(8'h06);
    chk("dp_is_Y", {7'h0, is_Y}, 8'h01);
    chk("dp_Disp", Disp, 8'h10);
    chk("dp_Source", Source, 8'h06);
    idle(20);
    chk("sat_XPT", {4'h0, XPT}, 8'h0F);
    chk("sat_ovf", {7'h0, xpt_overflow}, 8'h01);
    cyc(0, 8'h00, 0, 0, 0, 1);
    chk("sticky_ovf", {7'h0, xpt_overflow}, 8'h01);
    cyc(0, 8'h00, 0, 0, 1, 0);
    chk("idle_strobe_XPT", {4'h0, XPT}, 8'h00);

    // Plain prefix, with a held byte ignored in PFX
    feed(8'hDD);
    cyc(1, 8'hCB, 1, 0, 0, 0);
    feed(8'h21);
    chk("plain_pulse", {7'h0, pfx_plain}, 8'h01);
    chk("plain_Source", Source, 8'h21);
    idle(1);
    chk("plain_drop", {7'h0, pfx_plain}, 8'h00);

    // RESET mid-EXEC at XPT=7 while other inputs are active
    feed(8'hDD); feed(8'hCB); feed(8'h01); feed(8'h02);
    idle(7); chk("pre_rst_XPT", {4'h0, XPT}, 8'h07);
    RESET = 1;
    cyc(1, 8'hDD, 0, 1, 0, 0);
    RESET = 0;
    chk("mid_rst_notXPT", {4'h0, notXPT}, 8'h0F);
    chk("mid_rst_notSource", notSource, 8'hFF);
    chk("mid_rst_Disp", Disp, 8'h00);
    chk("mid_rst_ovf", {7'h0, xpt_overflow}, 8'h00);
    chk("mid_rst_not_enable", {7'h0, not_enable}, 8'h01);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
